// File: rtl/imm_pkg.sv
// imm_pkg: shared types and constants for the pipelined immediate generator.
//   imm_fmt_e : immediate format reported per lane.
//   OP_*      : base/FP opcode constants recognised by the lane decoder.
//   lane_t    : one decoded lane (32-bit immediate, format, unknown-opcode flag).
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_CSRI,
    FMT_NONE
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FLW    = 7'b0000111;
  localparam logic [6:0] OP_FSW    = 7'b0100111;

  // The immediate is kept at 32 bits: every format carries its sign in bit 31
  // (zero for the CSR uimm), so widening to XLEN is a single sign extension.
  typedef struct packed {
    logic [31:0] imm;
    imm_fmt_e    fmt;
    logic        illegal;
  } lane_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: valid/ready bundle interface of imm_gen_pipe.
//   Input side : in_valid, in_ready, in_instr (lane k at [32k+31:32k]).
//   Output side: out_valid, out_ready, out_imm (lane k at [XLEN*k +: XLEN]),
//                out_fmt (3 bits per lane), out_illegal (1 bit per lane).
//   slave  : view of the immediate generator.
//   master : view of the surrounding pipeline (producer + consumer).
interface imm_gen_pipe_if #(
  parameter int unsigned LANES = 1,
  parameter int unsigned XLEN  = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*32-1:0]   in_instr;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*XLEN-1:0] out_imm;
  logic [LANES*3-1:0]    out_fmt;
  logic [LANES-1:0]      out_illegal;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe_lane_dec.sv
// imm_lane_dec: combinational single-lane immediate decoder.
//   instr_i   : 32-bit instruction.
//   imm_o     : immediate sign-extended from instr_i[31] to XLEN.
//   fmt_o     : decoded immediate format (FMT_NONE for unknown opcodes).
//   illegal_o : unknown-opcode flag.
// Build option IMM_CSR_UIMM_EN: CSR*I forms yield zext(uimm) with FMT_CSRI.
module imm_lane_dec
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  lane_t lane;

  always_comb begin
    lane = '{imm: '1, fmt: FMT_NONE, illegal: 1'b1};
    case (instr_i[6:0])
      OP_LOAD, OP_OPIMM, OP_JALR, OP_FLW:
        lane = '{imm: {{20{instr_i[31]}}, instr_i[31:20]}, fmt: FMT_I, illegal: 1'b0};
      OP_SYSTEM: begin
        lane = '{imm: {{20{instr_i[31]}}, instr_i[31:20]}, fmt: FMT_I, illegal: 1'b0};
`ifdef IMM_CSR_UIMM_EN
        if (instr_i[14]) begin
          lane = '{imm: {27'b0, instr_i[19:15]}, fmt: FMT_CSRI, illegal: 1'b0};
        end
`endif
      end
      OP_STORE, OP_FSW:
        lane = '{imm: {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]},
                 fmt: FMT_S, illegal: 1'b0};
      OP_BRANCH:
        lane = '{imm: {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0},
                 fmt: FMT_B, illegal: 1'b0};
      OP_LUI, OP_AUIPC:
        lane = '{imm: {instr_i[31:12], 12'b0}, fmt: FMT_U, illegal: 1'b0};
      OP_JAL:
        lane = '{imm: {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0},
                 fmt: FMT_J, illegal: 1'b0};
      default: ;
    endcase
  end

  assign imm_o     = XLEN'($signed(lane.imm));
  assign fmt_o     = lane.fmt;
  assign illegal_o = lane.illegal;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: LANES-wide immediate generator behind a 2-entry skid buffer.
//   clk, rst : clock, synchronous active-high reset.
//   flush    : discard both buffered bundles (and any bundle accepted now).
//   bus      : imm_gen_pipe_if slave (in_valid/in_ready/in_instr,
//              out_valid/out_ready/out_imm/out_fmt/out_illegal).
// Main register M drives the outputs; skid register S catches the one bundle
// that can arrive while M is stalled. in_ready = !S.valid, purely registered.
// Build option IMM_CSR_UIMM_EN is handled inside imm_lane_dec.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned LANES = 1,
  parameter int unsigned XLEN  = 32
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  imm_gen_pipe_if.slave bus
);

  logic [LANES*XLEN-1:0] dec_imm;
  logic [LANES*3-1:0]    dec_fmt;
  logic [LANES-1:0]      dec_ill;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    imm_fmt_e lane_fmt;
    imm_lane_dec #(.XLEN(XLEN)) u_dec (
      .instr_i   (bus.in_instr[32*k +: 32]),
      .imm_o     (dec_imm[XLEN*k +: XLEN]),
      .fmt_o     (lane_fmt),
      .illegal_o (dec_ill[k])
    );
    assign dec_fmt[3*k +: 3] = lane_fmt;
  end

  logic                  m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [LANES*XLEN-1:0] m_imm_q, m_imm_d, s_imm_q, s_imm_d;
  logic [LANES*3-1:0]    m_fmt_q, m_fmt_d, s_fmt_q, s_fmt_d;
  logic [LANES-1:0]      m_ill_q, m_ill_d, s_ill_q, s_ill_d;

  logic accept, drain;
  assign accept = bus.in_valid && !s_valid_q;
  assign drain  = m_valid_q && bus.out_ready;

  // accept and drain-from-S are mutually exclusive since in_ready = !S.valid.
  always_comb begin
    m_valid_d = m_valid_q;
    m_imm_d   = m_imm_q;
    m_fmt_d   = m_fmt_q;
    m_ill_d   = m_ill_q;
    s_valid_d = s_valid_q;
    s_imm_d   = s_imm_q;
    s_fmt_d   = s_fmt_q;
    s_ill_d   = s_ill_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (drain) begin
      if (s_valid_q) begin
        m_imm_d   = s_imm_q;
        m_fmt_d   = s_fmt_q;
        m_ill_d   = s_ill_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_imm_d = dec_imm;
        m_fmt_d = dec_fmt;
        m_ill_d = dec_ill;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!m_valid_q) begin
        m_valid_d = 1'b1;
        m_imm_d   = dec_imm;
        m_fmt_d   = dec_fmt;
        m_ill_d   = dec_ill;
      end else begin
        s_valid_d = 1'b1;
        s_imm_d   = dec_imm;
        s_fmt_d   = dec_fmt;
        s_ill_d   = dec_ill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_imm_q   <= '0;
      m_fmt_q   <= {LANES{3'(FMT_NONE)}};
      m_ill_q   <= '0;
      s_valid_q <= 1'b0;
      s_imm_q   <= '0;
      s_fmt_q   <= {LANES{3'(FMT_NONE)}};
      s_ill_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_imm_q   <= m_imm_d;
      m_fmt_q   <= m_fmt_d;
      m_ill_q   <= m_ill_d;
      s_valid_q <= s_valid_d;
      s_imm_q   <= s_imm_d;
      s_fmt_q   <= s_fmt_d;
      s_ill_q   <= s_ill_d;
    end
  end

  assign bus.in_ready    = !s_valid_q;
  assign bus.out_valid   = m_valid_q;
  assign bus.out_imm     = m_imm_q;
  assign bus.out_fmt     = m_fmt_q;
  assign bus.out_illegal = m_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives a LANES=2/XLEN=64 instance and a LANES=1/XLEN=32
// instance with identical handshakes (the narrow one sees lane 0 only) and
// checks both against a bundle queue plus an arithmetic immediate model.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.LANES(2), .XLEN(64)) bus_w ();
  imm_gen_pipe_if #(.LANES(1), .XLEN(32)) bus_n ();

  imm_gen_pipe #(.LANES(2), .XLEN(64)) u_dut_w (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_w)
  );
  imm_gen_pipe #(.LANES(1), .XLEN(32)) u_dut_n (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_n)
  );

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
  } bundle_t;

  typedef struct {
    longint     imm;
    logic [2:0] fmt;
    logic       ill;
  } ref_t;

  bundle_t q[$];
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Immediate values rebuilt as signed arithmetic sums of the fields.
  function automatic ref_t ref_dec(input logic [31:0] ins);
    ref_t   r;
    longint sg;
    sg = ins[31] ? 64'sd1 : 64'sd0;
    r.ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h07, 7'h73: begin
        r.imm = -sg * 2048 + longint'(ins[30:20]);
        r.fmt = 3'(FMT_I);
`ifdef IMM_CSR_UIMM_EN
        if (ins[6:0] == 7'h73 && ins[14]) begin
          r.imm = longint'(ins[19:15]);
          r.fmt = 3'(FMT_CSRI);
        end
`endif
      end
      7'h23, 7'h27: begin
        r.imm = -sg * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
        r.fmt = 3'(FMT_S);
      end
      7'h63: begin
        r.imm = -sg * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                + longint'(ins[11:8]) * 2;
        r.fmt = 3'(FMT_B);
      end
      7'h37, 7'h17: begin
        r.imm = -sg * 64'sd2147483648 + longint'(ins[30:12]) * 4096;
        r.fmt = 3'(FMT_U);
      end
      7'h6F: begin
        r.imm = -sg * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                + longint'(ins[30:21]) * 2;
        r.fmt = 3'(FMT_J);
      end
      default: begin
        r.imm = -1;
        r.fmt = 3'(FMT_NONE);
        r.ill = 1'b1;
      end
    endcase
    return r;
  endfunction

  task automatic check_model();
    ref_t r0, r1;
    logic exp_rdy;
    exp_rdy = (q.size() < 2);
    chk("in_ready_w", 64'(bus_w.in_ready), 64'(exp_rdy));
    chk("in_ready_n", 64'(bus_n.in_ready), 64'(exp_rdy));
    chk("out_valid_w", 64'(bus_w.out_valid), 64'(q.size() > 0));
    chk("out_valid_n", 64'(bus_n.out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      r0 = ref_dec(q[0].i0);
      r1 = ref_dec(q[0].i1);
      chk("imm_w0", bus_w.out_imm[63:0], r0.imm);
      chk("imm_w1", bus_w.out_imm[127:64], r1.imm);
      chk("fmt_w0", 64'(bus_w.out_fmt[2:0]), 64'(r0.fmt));
      chk("fmt_w1", 64'(bus_w.out_fmt[5:3]), 64'(r1.fmt));
      chk("ill_w", 64'(bus_w.out_illegal), 64'({r1.ill, r0.ill}));
      chk("imm_n", 64'(bus_n.out_imm), 64'(r0.imm[31:0]));
      chk("fmt_n", 64'(bus_n.out_fmt), 64'(r0.fmt));
      chk("ill_n", 64'(bus_n.out_illegal), 64'(r0.ill));
    end
  endtask

  // One cycle: check state at the falling edge, drive inputs, advance model.
  task automatic step(input logic v, input logic r, input logic f,
                      input logic [31:0] i0, input logic [31:0] i1);
    logic acc, drn;
    bundle_t b;
    @(negedge clk);
    check_model();
    bus_w.in_valid  = v;
    bus_w.out_ready = r;
    bus_w.in_instr  = {i1, i0};
    bus_n.in_valid  = v;
    bus_n.out_ready = r;
    bus_n.in_instr  = i0;
    flush = f;
    acc = v && (q.size() < 2);
    drn = r && (q.size() > 0);
    if (f) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        b.i0 = i0;
        b.i1 = i1;
        q.push_back(b);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b0;
    bus_w.in_valid = 1'b0;
    bus_n.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    chk("rst_out_valid", 64'({bus_w.out_valid, bus_n.out_valid}), 64'd0);
    chk("rst_in_ready", 64'({bus_w.in_ready, bus_n.in_ready}), 64'd3);
    chk("rst_imm_w", bus_w.out_imm[63:0] | bus_w.out_imm[127:64], 64'd0);
    chk("rst_imm_n", 64'(bus_n.out_imm), 64'd0);
    chk("rst_fmt_w", 64'(bus_w.out_fmt), 64'({3'(FMT_NONE), 3'(FMT_NONE)}));
    chk("rst_fmt_n", 64'(bus_n.out_fmt), 64'(FMT_NONE));
    chk("rst_ill", 64'({bus_w.out_illegal, bus_n.out_illegal}), 64'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[11];
    logic [31:0] r;
    int unsigned sel;
    ops = '{7'h03, 7'h13, 7'h67, 7'h07, 7'h73, 7'h23, 7'h27, 7'h63, 7'h37, 7'h17, 7'h6F};
    r = $urandom();
    sel = $urandom_range(0, 13);
    if (sel < 11) r[6:0] = ops[sel];
    return r;
  endfunction

  initial begin
    bus_w.in_valid = 1'b0; bus_w.out_ready = 1'b0; bus_w.in_instr = '0;
    bus_n.in_valid = 1'b0; bus_n.out_ready = 1'b0; bus_n.in_instr = '0;
    do_reset();

    // addi x1,x0,-1 alongside an unknown opcode
    step(1, 1, 0, 32'hFFF00093, 32'h0000007F);
    step(0, 1, 0, 32'h0, 32'h0);
    chk("addi_imm_w", bus_w.out_imm[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_fmt_w", 64'(bus_w.out_fmt[2:0]), 64'(FMT_I));
    chk("addi_imm_n", 64'(bus_n.out_imm), 64'hFFFF_FFFF);
    chk("unk_imm", bus_w.out_imm[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("unk_fmt", 64'(bus_w.out_fmt[5:3]), 64'(FMT_NONE));
    chk("unk_ill", 64'(bus_w.out_illegal), 64'b10);

    // lui / jal
    step(1, 1, 0, 32'h800000B7, 32'h0080006F);
    step(0, 1, 0, 32'h0, 32'h0);
    chk("lui_imm_w", bus_w.out_imm[63:0], 64'hFFFF_FFFF_8000_0000);
    chk("lui_fmt", 64'(bus_w.out_fmt[2:0]), 64'(FMT_U));
    chk("lui_imm_n", 64'(bus_n.out_imm), 64'h8000_0000);
    chk("jal_imm", bus_w.out_imm[127:64], 64'd8);
    chk("jal_fmt", 64'(bus_w.out_fmt[5:3]), 64'(FMT_J));

    // beq -4 / sw 12
    step(1, 1, 0, 32'hFE000EE3, 32'h00112623);
    step(0, 1, 0, 32'h0, 32'h0);
    chk("beq_imm", bus_w.out_imm[63:0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_fmt", 64'(bus_w.out_fmt[2:0]), 64'(FMT_B));
    chk("sw_imm", bus_w.out_imm[127:64], 64'd12);
    chk("sw_fmt", 64'(bus_w.out_fmt[5:3]), 64'(FMT_S));

    // csrrwi x0,mstatus,15
    step(1, 1, 0, 32'h3007D073, 32'h3007D073);
    step(0, 1, 0, 32'h0, 32'h0);
`ifdef IMM_CSR_UIMM_EN
    chk("csri_imm", bus_w.out_imm[63:0], 64'd15);
    chk("csri_fmt", 64'(bus_w.out_fmt[2:0]), 64'(FMT_CSRI));
`else
    chk("csri_imm", bus_w.out_imm[63:0], 64'h300);
    chk("csri_fmt", 64'(bus_w.out_fmt[2:0]), 64'(FMT_I));
`endif

    // back-pressure: three back-to-back bundles, only two fit
    step(1, 0, 0, 32'h00100093, 32'h00200113);
    step(1, 0, 0, 32'h00300193, 32'h00400213);
    step(1, 0, 0, 32'h00500293, 32'h00600313);
    chk("bp_in_ready", 64'(bus_w.in_ready), 64'd0);
    chk("bp_hold_imm", bus_w.out_imm[63:0], 64'd1);
    repeat (3) step(0, 1, 0, 32'h0, 32'h0);

    // flush with both entries full and a concurrent input
    step(1, 0, 0, 32'h00700393, 32'h00800413);
    step(1, 0, 0, 32'h00900493, 32'h00A00513);
    step(1, 0, 1, 32'h00B00593, 32'h00C00613);
    step(0, 1, 0, 32'h0, 32'h0);
    chk("flush_out_valid", 64'(bus_w.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus_w.in_ready), 64'd1);
    repeat (3) step(0, 1, 0, 32'h0, 32'h0);

    // reset in the middle of a transfer
    step(1, 0, 0, rand_instr(), rand_instr());
    step(1, 0, 0, rand_instr(), rand_instr());
    do_reset();

    for (int unsigned c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 99) < 3), rand_instr(), rand_instr());
    end
    step(0, 1, 0, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage; successor to the single-instruction combinational extender.
- Handles LANES instructions per cycle, sign-extends to XLEN and reports the immediate format plus an unknown-opcode flag per lane.
- Output is registered behind a 2-entry skid buffer with valid/ready handshake on both sides, so the decode→execute path is timing-isolated and stall-tolerant.
- Sits between the fetch/decode register and the issue/operand-select logic.

Parameters:
- LANES, 1, instructions decoded per cycle (1..4).
- XLEN, 32, immediate output width (32 or 64).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all buffered entries this cycle.
- in_valid  in  1  input bundle valid.
- in_ready  out  1  block can accept a bundle.
- in_instr  in  LANES*32  instructions; lane k at [32k+31:32k].
- out_valid  out  1  output bundle valid.
- out_ready  in  1  consumer accepts the bundle.
- out_imm  out  LANES*XLEN  extended immediates; lane k at [XLEN*k+XLEN-1:XLEN*k].
- out_fmt  out  LANES*3  per-lane imm_fmt_e.
- out_illegal  out  LANES  per-lane unknown-opcode flag.

Behaviour:
- Decode per lane on opcode [6:0]:
  - I-type: 0000011 load, 0010011 ALU-imm, 1100111 JALR, 0000111 FLW, 1110011 CSR/SYSTEM. imm = sext(instr[31:20]).
  - S-type: 0100011 store, 0100111 FSW. imm = sext({[31:25],[11:7]}).
  - B-type: 1100011. imm = sext({[31],[7],[30:25],[11:8],0}).
  - U-type: 0110111 LUI, 0010111 AUIPC. imm = sext({[31:12],12'b0}); bit 31 replicates to XLEN.
  - J-type: 1101111. imm = sext({[31],[19:12],[20],[30:21],0}).
  - Any other opcode: imm = all-ones (XLEN bits), fmt = FMT_NONE, illegal = 1.
- Sign extension always fills to XLEN from instr[31].
- Storage: main register M (drives outputs) and skid register S, each holding a valid bit plus LANES payloads.
- in_ready = !S.valid, registered; it depends on no input combinationally.
- Accept: in_valid && in_ready.
  - If M is empty, or M drains this cycle (out_ready), the decoded data goes to M.
  - Otherwise the data goes to S.
- Drain: out_valid && out_ready.
  - If S is valid, S moves to M and S clears.
  - Otherwise M clears, unless an accept refills it in the same cycle.
- Latency: 1 cycle from accept to out_valid when empty. Throughput: 1 bundle/cycle with out_ready high.
- Back-pressure: out_* stay stable while out_valid && !out_ready. Lane order is preserved and bundles are never reordered.
- flush: M.valid and S.valid clear next cycle. An input accepted in the same cycle as flush is dropped, and in_ready is 1 the next cycle.
- Reset:
  - out_valid = 0, in_ready = 1 from the first cycle after reset.
  - out_imm = 0, out_fmt = FMT_NONE, out_illegal = 0.
  - Reset mid-transfer discards both entries.
- Simultaneous accept and drain with S valid cannot occur, because in_ready = 0 whenever S is valid.

Optional Feature:
- Macro: IMM_CSR_UIMM_EN.
- Defined: for opcode 1110011 with funct3[2] = 1 (CSRRWI/CSRRSI/CSRRCI), imm = zext(instr[19:15]) and fmt = FMT_CSRI.
- Undefined: every 1110011 encoding uses the I-type rule with fmt = FMT_I, and FMT_CSRI is never produced.

Decomposition:
- Package imm_pkg holds:
  - typedef enum logic [2:0] imm_fmt_e {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSRI, FMT_NONE}.
  - localparam opcode constants (OP_LOAD, OP_OPIMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM, OP_FLW, OP_FSW).
  - A struct {imm, fmt, illegal} for one lane.
- Sub-module imm_lane_dec: purely combinational single-lane decoder, parametrised by XLEN and instantiated LANES times in a generate loop.
- The top level owns the skid buffer and the handshake.

Test Plan:
- LANES=1, XLEN=32, in 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=FMT_I, illegal=0.
- XLEN=64, in 0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000, fmt=FMT_U. Then 0x0080006F (jal x0,8) -> imm=8, fmt=FMT_J.
- LANES=2, in {0xFE000EE3 (beq x0,x0,-4), 0x00112623 (sw x1,12(x2))} -> lane0 imm=0xFFFFFFFC fmt=FMT_B, lane1 imm=12 fmt=FMT_S.
- out_ready=0; push 3 back-to-back bundles -> first two held in M/S, in_ready=0 from the third cycle. Raise out_ready -> bundles emerge in order, one per cycle.
- in 0x0000007F (unknown opcode) -> imm=0xFFFFFFFF, fmt=FMT_NONE, illegal=1.
- With M and S full, assert flush together with an in_valid -> next cycle out_valid=0, in_ready=1, and no stale bundle is ever emitted.
- With IMM_CSR_UIMM_EN defined, in 0x3007D073 (csrrwi x0,mstatus,15) -> imm=15, fmt=FMT_CSRI. Without the macro -> imm=0x00000300, fmt=FMT_I.
